// File: rtl/wb_queue.sv
// In-order writeback FIFO feeding the register file write port.
// Define WBQ_FWD_EN to add the fwd_addr/fwd_hit/fwd_data lookup port.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        in_addr,
  input  logic [DW-1:0]        in_data,
  input  logic                 drain_en,
  output logic                 cnt,
  output logic [AW-1:0]        wta,
  output logic [DW-1:0]        wtd,
`ifdef WBQ_FWD_EN
  input  logic [AW-1:0]        fwd_addr,
  output logic                 fwd_hit,
  output logic [DW-1:0]        fwd_data,
`endif
  output logic [(1<<AW)-1:0]   pending
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] used;
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic          cnt_q, cnt_d;
  logic [AW-1:0] wta_q, wta_d;
  logic [DW-1:0] wtd_q, wtd_d;
  logic [DEPTH-1:0] live;
  logic          empty, full;
  logic          enq, deq;

  assign empty = (rd_q == wr_q);
  assign full  = (rd_q[IW-1:0] == wr_q[IW-1:0])
              && (rd_q[IW] != wr_q[IW]);
  assign in_ready = !full && !rst;
  // x0 writes complete the handshake but are dropped
  assign enq  = in_valid && in_ready && (in_addr != '0);
  assign deq  = drain_en && !empty;
  assign used = wr_q - rd_q;

  assign cnt = cnt_q;
  assign wta = wta_q;
  assign wtd = wtd_q;

  always_comb begin
    logic [IW-1:0] off;
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = IW'(i) - rd_q[IW-1:0];
      live[i] = ({1'b0, off} < used);
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) pending[addr_q[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

`ifdef WBQ_FWD_EN
  // walk oldest to newest so the newest match wins
  always_comb begin
    logic [IW-1:0] slot;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_q[IW-1:0] + IW'(k);
      if ((PW'(k) < used) && (fwd_addr != '0)
          && (addr_q[slot] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[slot];
      end
    end
  end
`endif

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = 1'b0;
    wta_d  = wta_q;
    wtd_d  = wtd_q;
    if (enq) begin
      addr_d[wr_q[IW-1:0]] = in_addr;
      data_d[wr_q[IW-1:0]] = in_data;
      wr_d = wr_q + PW'(1);
    end
    if (deq) begin
      cnt_d = 1'b1;
      wta_d = addr_q[rd_q[IW-1:0]];
      wtd_d = data_q[rd_q[IW-1:0]];
      rd_d  = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= 1'b0;
      wta_q <= '0;
      wtd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      wta_q  <= wta_d;
      wtd_q  <= wtd_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue with a write-order scoreboard.
// Covers the fwd port when WBQ_FWD_EN is defined.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic        cnt;
  logic [4:0]  wta;
  logic [31:0] wtd;
  logic [31:0] pending;
`ifdef WBQ_FWD_EN
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q [$];

  wb_queue dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .drain_en (drain_en),
    .cnt      (cnt),
    .wta      (wta),
    .wtd      (wtd),
`ifdef WBQ_FWD_EN
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
`endif
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every register file write must match the next expected entry
  always @(negedge clk) begin
    if (cnt === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(1), 64'(0));
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("sb_wta", 64'(wta), 64'(e[36:32]));
        chk("sb_wtd", 64'(wtd), 64'(e[31:0]));
      end
    end
  end

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("push_timeout", 64'(0), 64'(1));
    end else if (a != 5'd0) begin
      exp_q.push_back({a, d});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [31:0] drain_pend [4];

  initial begin
    drain_pend[0] = 32'h1C;
    drain_pend[1] = 32'h38;
    drain_pend[2] = 32'h30;
    drain_pend[3] = 32'h20;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_addr  = 5'd5;
    in_data  = 32'h55;
    drain_en = 1'b0;
`ifdef WBQ_FWD_EN
    fwd_addr = 5'd0;
`endif

    // reset held two edges with a valid input
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_cnt", 64'(cnt), 64'(0));
    chk("rst_wta", 64'(wta), 64'(0));
    chk("rst_wtd", 64'(wtd), 64'(0));
    chk("rst_pending", 64'(pending), 64'(0));
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'(1));
    chk("post_rst_pending", 64'(pending), 64'(0));

    // fill to full
    push(5'd1, 32'h11);
    push(5'd2, 32'h22);
    push(5'd3, 32'h33);
    push(5'd4, 32'h44);
    chk("full_ready", 64'(in_ready), 64'(0));
    chk("full_pending", 64'(pending), 64'(32'h1E));
    in_valid = 1'b1;
    in_addr  = 5'd5;
    in_data  = 32'h55;
    exp_q.push_back({5'd5, 32'h55});
    repeat (3) @(negedge clk);
    chk("held_ready", 64'(in_ready), 64'(0));
    chk("held_pending", 64'(pending), 64'(32'h1E));
    chk("held_cnt", 64'(cnt), 64'(0));

    // drain: four back-to-back writes, fifth entry follows
    drain_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_cnt", 64'(cnt), 64'(1));
      chk("drain_pending", 64'(pending), 64'(drain_pend[k]));
      if (k == 0) chk("drain_ready", 64'(in_ready), 64'(1));
      if (k == 1) in_valid = 1'b0;
    end
    @(negedge clk);
    chk("fifth_cnt", 64'(cnt), 64'(1));
    chk("fifth_wta", 64'(wta), 64'(5));
    chk("fifth_pending", 64'(pending), 64'(0));
    @(negedge clk);
    chk("drained_cnt", 64'(cnt), 64'(0));

    // x0 is accepted and dropped
    push(5'd0, 32'hFF);
    repeat (2) @(negedge clk);
    chk("x0_pending", 64'(pending), 64'(0));
    chk("x0_cnt", 64'(cnt), 64'(0));

    // duplicate destinations while draining
    in_valid = 1'b1;
    in_addr  = 5'd7;
    in_data  = 32'hA;
    #1;
    chk("dup_ready", 64'(in_ready), 64'(1));
    exp_q.push_back({5'd7, 32'hA});
    @(negedge clk);
    chk("no_bypass_cnt", 64'(cnt), 64'(0));
    chk("dup_pend_a", 64'(pending), 64'(32'h80));
    in_data = 32'hB;
    exp_q.push_back({5'd7, 32'hB});
    @(negedge clk);
    in_valid = 1'b0;
    chk("dup_pend_b", 64'(pending), 64'(32'h80));
    chk("dup_cnt_a", 64'(cnt), 64'(1));
    chk("dup_wtd_a", 64'(wtd), 64'(32'hA));
    @(negedge clk);
    chk("dup_pend_clr", 64'(pending), 64'(0));
    chk("dup_wtd_b", 64'(wtd), 64'(32'hB));
    @(negedge clk);

    // reset mid-operation discards queued entries
    drain_en = 1'b0;
    push(5'd3, 32'h300);
    push(5'd4, 32'h400);
    push(5'd5, 32'h500);
    chk("mid_pending", 64'(pending), 64'(32'h38));
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    drain_en = 1'b1;
    #1;
    chk("mid_post_pending", 64'(pending), 64'(0));
    chk("mid_post_cnt", 64'(cnt), 64'(0));
    chk("mid_post_ready", 64'(in_ready), 64'(1));
    repeat (6) @(negedge clk);
    chk("mid_quiet_cnt", 64'(cnt), 64'(0));

`ifdef WBQ_FWD_EN
    drain_en = 1'b0;
    push(5'd9, 32'h1);
    push(5'd9, 32'h2);
    fwd_addr = 5'd9;
    #1;
    chk("fwd_hit", 64'(fwd_hit), 64'(1));
    chk("fwd_data", 64'(fwd_data), 64'(2));
    fwd_addr = 5'd0;
    #1;
    chk("fwd_x0_hit", 64'(fwd_hit), 64'(0));
    chk("fwd_x0_data", 64'(fwd_data), 64'(0));
    drain_en = 1'b1;
`endif

    repeat (8) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
